// File: rtl/corefifo_bin_to_gray_wptr_if.sv
// Bus between the producer/read-domain side and the write-pointer generator.
// The master drives the write request and the read-domain Gray pointer.
// The slave (the pointer generator) drives the RAM write port, the Gray write
// pointer and the status flags.
interface corefifo_bin_to_gray_wptr_if #(
  parameter int unsigned ADDRWIDTH = 3
);
  logic                 wr_en;
  logic [ADDRWIDTH:0]   rd_gray_in;
  logic [ADDRWIDTH-1:0] wr_addr;
  logic                 wr_we;
  logic [ADDRWIDTH:0]   wr_gray_out;
  logic                 full;
  logic                 wr_ack;
  logic                 overflow;
  logic                 afull;

  modport master (
    output wr_en, rd_gray_in,
    input  wr_addr, wr_we, wr_gray_out, full, wr_ack, overflow, afull
  );

  modport slave (
    input  wr_en, rd_gray_in,
    output wr_addr, wr_we, wr_gray_out, full, wr_ack, overflow, afull
  );
endinterface

// File: rtl/corefifo_bin_to_gray_wptr.sv
// Write-side pointer generator for the async calibrator FIFOs.
// - Keeps the binary write pointer and publishes it as a registered Gray code.
// - Synchronises the read-domain Gray pointer and derives a registered FULL.
// - Optional almost-full flag, enabled by defining CAL_FIFO_AFULL_EN; when it is
//   undefined there is no decoder/subtractor and afull is tied low.
module corefifo_bin_to_gray_wptr #(
  parameter int unsigned ADDRWIDTH    = 3,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned AFULL_THRESH = 6
) (
  input logic                        clk,
  input logic                        rstn,
  corefifo_bin_to_gray_wptr_if.slave bus
);
  localparam int unsigned PW = ADDRWIDTH + 1;

  if (ADDRWIDTH < 2) begin : g_bad_addrwidth
    $error("ADDRWIDTH must be at least 2");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("SYNC_STAGES must be at least 2");
  end
  if ((AFULL_THRESH < 1) || (AFULL_THRESH >= (1 << ADDRWIDTH))) begin : g_bad_afull_thresh
    $error("AFULL_THRESH must be within 1..2**ADDRWIDTH-1");
  end

  logic [PW-1:0]                  wr_bin;
  logic [PW-1:0]                  wr_gray;
  logic [PW-1:0]                  bin_nxt;
  logic [PW-1:0]                  gray_nxt;
  logic [PW-1:0]                  full_match;
  logic [SYNC_STAGES-1:0][PW-1:0] sync_q;
  logic [PW-1:0]                  rd_gray_s;
  logic                           accept;
  logic                           full_q;
  logic                           ack_q;
  logic                           ovf_q;

  assign rd_gray_s = sync_q[SYNC_STAGES-1];

  // Next pointer values; bin_nxt/gray_nxt hold the current value when nothing is accepted
  always_comb begin
    accept     = bus.wr_en & ~full_q;
    bin_nxt    = accept ? (wr_bin + 1'b1) : wr_bin;
    gray_nxt   = bin_nxt ^ (bin_nxt >> 1);
    full_match = {~rd_gray_s[PW-1:PW-2], rd_gray_s[PW-3:0]};
  end

  // Read-pointer synchroniser: the raw asynchronous input only feeds stage 0
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.rd_gray_in};
    end
  end

  // Pointer, Gray output and status registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_bin  <= '0;
      wr_gray <= '0;
      full_q  <= 1'b0;
      ack_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wr_bin  <= bin_nxt;
      wr_gray <= gray_nxt;
      full_q  <= (gray_nxt == full_match);
      ack_q   <= accept;
      ovf_q   <= bus.wr_en & full_q;
    end
  end

`ifdef CAL_FIFO_AFULL_EN
  logic [PW-1:0] rd_bin_s;
  logic [PW-1:0] occ_nxt;
  logic          afull_q;

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it
  always_comb begin
    rd_bin_s = '0;
    for (int unsigned i = 0; i < PW; i++) begin
      rd_bin_s[i] = ^(rd_gray_s >> i);
    end
    occ_nxt = bin_nxt - rd_bin_s;
  end

  // Almost-full register, same latency as full
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      afull_q <= 1'b0;
    end else begin
      afull_q <= (occ_nxt >= PW'(AFULL_THRESH));
    end
  end

  assign bus.afull = afull_q;
`else
  assign bus.afull = 1'b0;
`endif

  assign bus.wr_addr     = wr_bin[ADDRWIDTH-1:0];
  assign bus.wr_we       = accept;
  assign bus.wr_gray_out = wr_gray;
  assign bus.full        = full_q;
  assign bus.wr_ack      = ack_q;
  assign bus.overflow    = ovf_q;
endmodule
